// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM
// and fills the IF/ID register, applying exception, interrupt, redirect and stall control.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
   parameter logic [31:0] EXC_VEC  = 32'h8000_0008,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        exc_req,
   input  logic        irq_req,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc_plus4,
   output logic        id_valid
);

   logic [31:0] pc_r;
   logic [31:0] pc_plus4_s;
   logic        irq_take_s;
   logic [31:0] pc_nxt_s;
   logic [31:0] inst_nxt_s;
   logic [31:0] pc4_nxt_s;
   logic        valid_nxt_s;

   assign rom_addr = pc_r;

   // Kernel flag (bit 31) is untouched by the increment; the low 31 bits wrap.
   assign pc_plus4_s = {pc_r[31], pc_r[30:0] + 31'd4};
   assign irq_take_s = irq_req & ~pc_r[31];

   // Next-state selection in priority order: exception, interrupt, redirect, stall, fetch.
   always_comb begin
      pc_nxt_s    = pc_r;
      inst_nxt_s  = id_inst;
      pc4_nxt_s   = id_pc_plus4;
      valid_nxt_s = id_valid;
      if (exc_req) begin
         pc_nxt_s    = EXC_VEC;
         inst_nxt_s  = NOP_INST;
         pc4_nxt_s   = pc_plus4_s;
         valid_nxt_s = 1'b0;
      end else if (irq_take_s) begin
         // EPC must resume the fetch that never issued, so record pc itself.
         pc_nxt_s    = IRQ_VEC;
         inst_nxt_s  = NOP_INST;
         pc4_nxt_s   = pc_r;
         valid_nxt_s = 1'b0;
      end else if (redirect_valid) begin
         pc_nxt_s    = redirect_target;
         inst_nxt_s  = NOP_INST;
         pc4_nxt_s   = pc_plus4_s;
         valid_nxt_s = 1'b0;
      end else if (stall) begin
         pc_nxt_s    = pc_r;
         inst_nxt_s  = id_inst;
         pc4_nxt_s   = id_pc_plus4;
         valid_nxt_s = id_valid;
      end else begin
         pc_nxt_s    = pc_plus4_s;
         inst_nxt_s  = rom_data;
         pc4_nxt_s   = pc_plus4_s;
         valid_nxt_s = 1'b1;
      end
   end

   // PC and IF/ID pipeline register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_r        <= RESET_PC;
         id_inst     <= NOP_INST;
         id_pc_plus4 <= 32'h0000_0000;
         id_valid    <= 1'b0;
      end else begin
         pc_r        <= pc_nxt_s;
         id_inst     <= inst_nxt_s;
         id_pc_plus4 <= pc4_nxt_s;
         id_valid    <= valid_nxt_s;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed scenarios then randomized traffic,
// checked against a behavioural model of the fetch rules.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0000_0000;
   logic        exc_req = 1'b0;
   logic        irq_req = 1'b0;
   logic [31:0] id_inst;
   logic [31:0] id_pc_plus4;
   logic        id_valid;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        v;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   bit   done = 1'b0;

   // Behavioural model state
   logic [31:0] m_pc   = RESET_PC;
   logic [31:0] m_inst = NOP_INST;
   logic [31:0] m_pc4  = 32'h0000_0000;
   logic        m_v    = 1'b0;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      return w ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] seq_pc(input logic [31:0] p);
      logic [31:0] lo;
      lo = (p + 32'd4) & 32'h7FFF_FFFF;
      return (p & 32'h8000_0000) | lo;
   endfunction

   assign rom_data = rom_word(rom_addr);

   if_fetch_stage dut (
      .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .exc_req(exc_req), .irq_req(irq_req), .id_inst(id_inst),
      .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
   );

   always #5 clk = ~clk;

   task automatic step(input logic rst, input logic st, input logic rv,
                       input logic [31:0] tg, input logic ex, input logic ir);
      exp_t e;
      @(negedge clk);
      reset = rst; stall = st; redirect_valid = rv; redirect_target = tg;
      exc_req = ex; irq_req = ir;
      if (!rst) begin
         m_pc = RESET_PC; m_inst = NOP_INST; m_pc4 = 32'h0000_0000; m_v = 1'b0;
      end else if (ex) begin
         m_inst = NOP_INST; m_v = 1'b0; m_pc4 = seq_pc(m_pc); m_pc = EXC_VEC;
      end else if (ir && (m_pc < 32'h8000_0000)) begin
         m_inst = NOP_INST; m_v = 1'b0; m_pc4 = m_pc; m_pc = IRQ_VEC;
      end else if (rv) begin
         m_inst = NOP_INST; m_v = 1'b0; m_pc4 = seq_pc(m_pc); m_pc = tg;
      end else if (!st) begin
         m_inst = rom_word(m_pc); m_v = 1'b1; m_pc4 = seq_pc(m_pc); m_pc = seq_pc(m_pc);
      end
      e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.v = m_v;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // Monitor: after each rising edge compare DUT outputs with the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("rom_addr", rom_addr, e.pc);
         chk("id_inst", id_inst, e.inst);
         chk("id_pc_plus4", id_pc_plus4, e.pc4);
         chk("id_valid", {31'd0, id_valid}, {31'd0, e.v});
      end
   end

   initial begin
      // Reset and free run up to pc 0x80000010
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      run(4);
      // Stall for 3 cycles, then release
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      run(2);
      // Redirect to 0x18 from pc 0x0C, plain and with stall
      step(1'b1, 1'b0, 1'b1, 32'h8000_000C, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h8000_0018, 1'b0, 1'b0);
      run(2);
      step(1'b1, 1'b0, 1'b1, 32'h8000_000C, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h8000_0018, 1'b0, 1'b0);
      run(2);
      // Interrupt in user mode, then ignored in kernel mode
      step(1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      run(1);
      step(1'b1, 1'b0, 1'b1, 32'h8000_0020, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      run(1);
      // Exception beats redirect; wrap of user-mode PC
      step(1'b1, 1'b0, 1'b1, 32'h8000_0040, 1'b1, 1'b0);
      run(1);
      step(1'b1, 1'b0, 1'b1, 32'h7FFF_FFFC, 1'b0, 1'b0);
      run(2);
      // Reset mid-stall with redirect pending
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 1'b0);
      run(2);
      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] tg;
         logic        rs, st, rv, ex, ir;
         tg = $urandom();
         if ($urandom_range(0, 3) == 0) tg = {tg[31], 31'h7FFF_FFF0 | {27'd0, tg[3:0]}};
         rs = ($urandom_range(0, 99) >= 2);
         st = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 6) == 0);
         ex = ($urandom_range(0, 19) == 0);
         ir = ($urandom_range(0, 4) == 0);
         step(rs, st, rv, tg, ex, ir);
      end
      run(1);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS CPU: the reading side of the combinational instruction ROM. It owns the program counter, drives the ROM word address, and captures the returned instruction into the IF/ID pipeline register. It also applies stall, branch/jump redirect, exception and interrupt vectoring, and bubble insertion.

## Interface
- RESET_PC, 32'h8000_0000, PC after reset (kernel mode)
- IRQ_VEC, 32'h8000_0004, interrupt vector
- EXC_VEC, 32'h8000_0008, exception vector
- NOP_INST, 32'h0000_0000, bubble instruction (sll $0,$0,0)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- rom_addr  out  32  byte address to ROM; equals current PC
- rom_data  in  32  instruction returned combinationally for rom_addr
- stall  in  1  hold PC and IF/ID (load-use hazard from ID)
- redirect_valid  in  1  taken branch or jump resolved in ID
- redirect_target  in  32  new PC for redirect
- exc_req  in  1  exception raised downstream
- irq_req  in  1  external interrupt request, level
- id_inst  out  32  IF/ID instruction
- id_pc_plus4  out  32  IF/ID PC+4, used for link and EPC
- id_valid  out  1  IF/ID holds a real instruction

## Operation
- PC register `pc`; rom_addr = pc, combinational, no extra logic.
- Sequential next PC = {pc[31], pc[30:0] + 4}: bit 31 (kernel flag) is never changed by increment; bits 30:0 wrap modulo 2^31.
- Interrupt acceptance: `irq_take = irq_req & ~pc[31]`; interrupts are masked in kernel mode.
- Per-edge priority, highest first:
  1. reset low → pc=RESET_PC, id_inst=NOP_INST, id_pc_plus4=0, id_valid=0.
  2. exc_req → pc=EXC_VEC; IF/ID loads a bubble.
  3. irq_take → pc=IRQ_VEC; IF/ID loads a bubble; id_pc_plus4 loads the current pc, so EPC resumes the un-issued instruction.
  4. redirect_valid → pc=redirect_target, used unmodified (kernel bit included); IF/ID loads a bubble, squashing the wrong-path fetch.
  5. stall → pc and IF/ID hold.
  6. otherwise → pc=sequential next; id_inst=rom_data, id_pc_plus4={pc[31], pc[30:0]+4}, id_valid=1.
- Bubble means id_inst=NOP_INST, id_valid=0. id_pc_plus4 takes the pc+4 of the squashed fetch, except in case 3.
- Redirect, exception and interrupt all override stall.
- Alignment: redirect_target[1:0] is not checked. The ROM ignores addr[1:0].

## Timing
- ROM read is combinational: the instruction at pc appears on id_inst one edge after pc is presented. Fetch-to-ID latency is 1 cycle.
- Redirect asserted in cycle N: pc=target after edge N, and id_valid=0 for exactly one cycle. The target instruction reaches ID after edge N+1. Branch penalty is 1 bubble.
- Exception or interrupt: vector fetched in the cycle after the request, with 1 bubble.
- Stall held for k cycles: pc, id_inst, id_pc_plus4 and id_valid are frozen for k edges. No instruction is lost or duplicated.
- Reset mid-operation: the next edge with reset low forces all state to reset values, regardless of other inputs. The first real fetch is at RESET_PC on the first edge after reset returns high.
- All outputs are registered except rom_addr, which is pc.

## Test plan
- Reset, then free run with a ROM returning addr as data: rom_addr goes 0x80000000, 0x80000004, 0x80000008. id_inst lags by 1 cycle, id_pc_plus4 = addr+4, id_valid rises on the 2nd edge.
- Stall high for 3 cycles at pc=0x80000010: pc stays 0x80000010 and IF/ID is frozen. After release, the next id_inst is the 0x80000010 word exactly once.
- redirect_valid with target 0x80000018 at pc=0x8000000C: next pc=0x80000018, id_valid=0 for one cycle, then id_inst = word at 0x18. Repeat with stall also high: redirect must still win.
- User mode pc=0x00000020 with irq_req=1: pc→0x80000004, bubble inserted, id_pc_plus4=0x00000020. In kernel mode (pc=0x80000020), irq_req=1 is ignored.
- exc_req and redirect_valid in the same cycle: pc=0x80000008 and the redirect is dropped. Also at pc=0x7FFFFFFC, a sequential step gives 0x00000000 (kernel bit preserved at 0).
- Assert reset low mid-stall with redirect pending: next edge gives pc=0x80000000, id_valid=0, id_inst=0.
